// File: rtl/vc_ingress_logic_if.sv
// Main-FIFO read side and VC0/VC1 write side of the ingress stage.
// The slave modport is the ingress logic itself; master is its environment.
interface vc_ingress_logic_if #(parameter int DATA_W = 6);
  logic [DATA_W-1:0] data_in_main;
  logic              empty_main;
  logic              pop_main;
  logic              almost_full_VC0;
  logic              almost_full_VC1;
  logic              push_VC0;
  logic              push_VC1;
  logic [DATA_W-1:0] data_in_VC0;
  logic [DATA_W-1:0] data_in_VC1;

  modport slave (
    input  data_in_main, empty_main, almost_full_VC0, almost_full_VC1,
    output pop_main, push_VC0, push_VC1, data_in_VC0, data_in_VC1
  );

  modport master (
    output data_in_main, empty_main, almost_full_VC0, almost_full_VC1,
    input  pop_main, push_VC0, push_VC1, data_in_VC0, data_in_VC1
  );
endinterface

// File: rtl/vc_ingress_logic.sv
// Drains the FWFT main FIFO and steers each word to VC0/VC1 by its class bits;
// illegal classes are popped and dropped with an error pulse.

// One VC write port: registered push/data plus its push counter.
module vc_ingress_lane #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic [DATA_W-1:0] word,
  output logic              push,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push  <= 1'b0;
      data  <= '0;
      count <= '0;
    end else begin
      push <= sel;
      if (sel) begin
        data  <= word;
        count <= count + CNT_W'(1);
      end
    end
  end
endmodule

module vc_ingress_logic #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset_L,
  vc_ingress_logic_if.slave   bus,
  output logic                error_out,
  output logic                idle_out,
  output logic                active_out,
  output logic [CNT_W-1:0]    count_VC0,
  output logic [CNT_W-1:0]    count_VC1,
  output logic [CNT_W-1:0]    count_drop
);
  localparam int NUM_VC = 2;

  typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;

  state_t                          state, state_nxt;
  logic [1:0]                      cls;
  logic                            illegal, blocked, pop;
  logic [NUM_VC-1:0]               af, lane_sel, lane_push;
  logic [NUM_VC-1:0][DATA_W-1:0]   lane_data;
  logic [NUM_VC-1:0][CNT_W-1:0]    lane_cnt;

  assign cls     = bus.data_in_main[DATA_W-1 -: 2];
  assign illegal = cls[1];
  assign af      = {bus.almost_full_VC1, bus.almost_full_VC0};

  // Illegal words are never blocked: they drain regardless of VC back-pressure.
  assign blocked = ~illegal & af[cls[0]];
  assign pop     = reset_L & ~bus.empty_main & ~blocked;
  assign bus.pop_main = pop;

  genvar i;
  generate
    for (i = 0; i < NUM_VC; i++) begin : g_lane
      assign lane_sel[i] = pop & (cls == 2'(i));
      vc_ingress_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane (
        .clk   (clk),
        .rst_n (reset_L),
        .sel   (lane_sel[i]),
        .word  (bus.data_in_main),
        .push  (lane_push[i]),
        .data  (lane_data[i]),
        .count (lane_cnt[i])
      );
    end
  endgenerate

  assign bus.push_VC0    = lane_push[0];
  assign bus.push_VC1    = lane_push[1];
  assign bus.data_in_VC0 = lane_data[0];
  assign bus.data_in_VC1 = lane_data[1];
  assign count_VC0       = lane_cnt[0];
  assign count_VC1       = lane_cnt[1];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      error_out  <= 1'b0;
      count_drop <= '0;
    end else begin
      error_out <= pop & illegal;
      if (pop & illegal) count_drop <= count_drop + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.empty_main ? IDLE : (blocked ? STALL : ACTIVE);
      ACTIVE:  state_nxt = bus.empty_main ? IDLE : (blocked ? STALL : ACTIVE);
      STALL:   state_nxt = bus.empty_main ? IDLE : (blocked ? STALL : ACTIVE);
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= IDLE;
      idle_out   <= 1'b1;
      active_out <= 1'b0;
    end else begin
      state      <= state_nxt;
      idle_out   <= (state_nxt == IDLE);
      active_out <= (state_nxt == ACTIVE);
    end
  end
endmodule

// File: tb/tb_vc_ingress_logic.sv
// Scoreboard bench: a queue models the main FIFO, popped words are pushed into
// per-VC expectation queues and retired when the DUT raises push_VCx.
module tb_vc_ingress_logic;
  localparam int DATA_W = 6;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic error_out, idle_out, active_out;
  logic [CNT_W-1:0] count_VC0, count_VC1, count_drop;

  vc_ingress_logic_if #(.DATA_W(DATA_W)) bus ();

  vc_ingress_logic #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .bus        (bus),
    .error_out  (error_out),
    .idle_out   (idle_out),
    .active_out (active_out),
    .count_VC0  (count_VC0),
    .count_VC1  (count_VC1),
    .count_drop (count_drop)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  logic [CNT_W-1:0]  m_cnt0, m_cnt1, m_drop;
  logic [DATA_W-1:0] m_last0, m_last1;
  int                m_state; // 0 idle, 1 active, 2 stall

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q0.delete(); q1.delete();
    m_cnt0 = '0; m_cnt1 = '0; m_drop = '0;
    m_last0 = '0; m_last1 = '0;
    m_state = 0;
  endtask

  // One clock: present head, check pop before the edge, check outputs after it.
  task automatic step();
    logic e, blk, p;
    logic [DATA_W-1:0] h, w;
    logic [1:0] c;
    e = (mq.size() == 0);
    h = e ? '0 : mq[0];
    bus.empty_main   = e;
    bus.data_in_main = h;
    c   = h[DATA_W-1 -: 2];
    blk = (c == 2'b00 && bus.almost_full_VC0) || (c == 2'b01 && bus.almost_full_VC1);
    p   = reset_L && !e && !blk;
    #1;
    check("pop_main", int'(bus.pop_main), int'(p));
    @(posedge clk); #1;
    if (reset_L) begin
      m_state = e ? 0 : (blk ? 2 : 1);
      if (p) begin
        void'(mq.pop_front());
        case (c)
          2'b00:   begin q0.push_back(h); m_cnt0++; end
          2'b01:   begin q1.push_back(h); m_cnt1++; end
          default: m_drop++;
        endcase
      end
    end
    check("push_VC0", int'(bus.push_VC0), int'(p && c == 2'b00));
    check("push_VC1", int'(bus.push_VC1), int'(p && c == 2'b01));
    check("error_out", int'(error_out), int'(p && c[1]));
    if (bus.push_VC0 && q0.size() > 0) begin w = q0.pop_front(); m_last0 = w; end
    if (bus.push_VC1 && q1.size() > 0) begin w = q1.pop_front(); m_last1 = w; end
    check("data_VC0", int'(bus.data_in_VC0), int'(m_last0));
    check("data_VC1", int'(bus.data_in_VC1), int'(m_last1));
    check("count_VC0", int'(count_VC0), int'(m_cnt0));
    check("count_VC1", int'(count_VC1), int'(m_cnt1));
    check("count_drop", int'(count_drop), int'(m_drop));
    check("idle_out", int'(idle_out), int'(m_state == 0));
    check("active_out", int'(active_out), int'(m_state == 1));
  endtask

  task automatic drain(input int budget);
    int g = 0;
    while (mq.size() > 0 && g < budget) begin step(); g++; end
    check("drain_left", mq.size(), 0);
    step(); // let the FSM see empty
  endtask

  initial begin
    bus.data_in_main = '0;
    bus.empty_main = 1'b1;
    bus.almost_full_VC0 = 1'b0;
    bus.almost_full_VC1 = 1'b0;
    model_clear();

    // 1: reset held with a word waiting
    mq.push_back(6'b000101);
    repeat (2) step();
    check("rst_idle", int'(idle_out), 1);
    check("rst_cnt0", int'(count_VC0), 0);
    mq.delete();
    @(negedge clk); reset_L = 1'b1;
    step();

    // 2: three-word mixed stream, no back-pressure
    mq.push_back(6'b000101); mq.push_back(6'b010011); mq.push_back(6'b001110);
    drain(10);
    check("t2_cnt0", int'(count_VC0), 2);
    check("t2_cnt1", int'(count_VC1), 1);

    // 3: blocked VC0 head holds back a VC1 word
    bus.almost_full_VC0 = 1'b1;
    mq.push_back(6'b000001); mq.push_back(6'b010010);
    repeat (3) step();
    check("t3_wait", mq.size(), 2);
    bus.almost_full_VC0 = 1'b0;
    drain(10);

    // 4: illegal class word dropped
    mq.push_back(6'b100111);
    drain(10);
    check("t4_drop", int'(count_drop), 1);

    // 6: reset the cycle after a pop
    mq.push_back(6'b011111);
    step();
    reset_L = 1'b0;
    model_clear();
    #1;
    check("t6_push1", int'(bus.push_VC1), 0);
    check("t6_cnt1", int'(count_VC1), 0);
    check("t6_pop", int'(bus.pop_main), 0);
    @(negedge clk); reset_L = 1'b1;
    step();

    // 5: 256 VC1 words wrap the counter
    for (int k = 0; k < 256; k++) mq.push_back({2'b01, 4'(k)});
    bus.almost_full_VC1 = 1'b0;
    drain(400);
    check("t5_cnt1_wrap", int'(count_VC1), 0);
    check("t5_cnt0", int'(count_VC0), 0);

    // mixed random traffic with toggling back-pressure
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 2) != 0) mq.push_back(6'($urandom));
      bus.almost_full_VC0 = ($urandom_range(0, 3) == 0);
      bus.almost_full_VC1 = ($urandom_range(0, 3) == 0);
      step();
    end
    bus.almost_full_VC0 = 1'b0;
    bus.almost_full_VC1 = 1'b0;
    drain(400);
    check("sb_q0_left", q0.size(), 0);
    check("sb_q1_left", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
